// File: rtl/time_of_day_counter.sv
// Time-of-day counter: keeps wall-clock time as packed BCD hh:mm:ss from a
// 1 Hz strobe, with minute/hour adjust buttons, a validated parallel load,
// a one-deep deferral slot for ticks that collide with user actions, and
// one-cycle carry strobes for each counted second, minute and hour.
module time_of_day_counter #(
  parameter bit HOUR_24 = 1'b1   // 1: 00..23; 0: 12,01..11 with o_pm
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tick_1hz,
  input  logic        i_run,
  input  logic        i_inc_min,
  input  logic        i_inc_hr,
  input  logic        i_load,
  input  logic [23:0] i_load_time,
  input  logic        i_load_pm,
  output logic [23:0] o_time,
  output logic        o_pm,
  output logic        o_sec_pulse,
  output logic        o_min_pulse,
  output logic        o_hr_pulse,
  output logic        o_load_err,
  output logic        o_tick_lost
);

  // Two BCD digits (tens, ones) and the full hh:mm:ss packing of o_time.
  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
  } bcd2_t;

  typedef struct packed {
    bcd2_t hh;
    bcd2_t mm;
    bcd2_t ss;
  } tod_t;

  // Midnight reads 00 on a 24-hour clock and 12 (AM) on a 12-hour clock.
  localparam bcd2_t HR_RESET = bcd2_t'(HOUR_24 ? 8'h00 : 8'h12);

  // Minute/second step: 00..59, ones roll into tens, 59 wraps to 00.
  function automatic bcd2_t inc_60(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.o == 4'd9) begin
      r.o = 4'd0;
      r.t = (v.t == 4'd5) ? 4'd0 : v.t + 4'd1;
    end else begin
      r.o = v.o + 4'd1;
    end
    return r;
  endfunction

  // Hour step: 23->00 in 24-hour mode, 12->01 in 12-hour mode; 11->12 and
  // 09->10 fall out of the ordinary ones/tens rule.
  function automatic bcd2_t inc_hour(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (HOUR_24 && v == 8'h23) begin
      r = 8'h00;
    end else if (!HOUR_24 && v == 8'h12) begin
      r = 8'h01;
    end else if (v.o == 4'd9) begin
      r.o = 4'd0;
      r.t = v.t + 4'd1;
    end else begin
      r.o = v.o + 4'd1;
    end
    return r;
  endfunction

  // AM/PM flips only when a 12-hour clock steps from 11 to 12.
  function automatic logic pm_flips(input bcd2_t v);
    return !HOUR_24 && v == 8'h11;
  endfunction

  // A load is accepted only if every digit is decimal and the fields are in range.
  function automatic logic load_ok(input tod_t v);
    logic digits_ok;
    logic hh_ok;
    digits_ok = (v.hh.t <= 4'd9) && (v.hh.o <= 4'd9) &&
                (v.mm.t <= 4'd5) && (v.mm.o <= 4'd9) &&
                (v.ss.t <= 4'd5) && (v.ss.o <= 4'd9);
    if (HOUR_24) begin
      hh_ok = (v.hh.t < 4'd2) || (v.hh.t == 4'd2 && v.hh.o <= 4'd3);
    end else begin
      hh_ok = (v.hh.t == 4'd0 && v.hh.o != 4'd0) ||
              (v.hh.t == 4'd1 && v.hh.o <= 4'd2);
    end
    return digits_ok && hh_ok;
  endfunction

  tod_t tod_q, tod_d;
  logic pm_q, pm_d;
  logic pending_q, pending_d;
  logic lost_q, lost_d;
  logic sec_q, sec_d;
  logic min_q, min_d;
  logic hr_q, hr_d;
  logic err_q, err_d;

  logic user_event;
  logic tick;
  tod_t load_val;

  assign user_event = i_load | i_inc_hr | i_inc_min;
  assign tick       = i_tick_1hz & i_run;
  assign load_val   = tod_t'(i_load_time);

  // Next-state: apply load > hour > minute > tick, and manage the deferred tick.
  always_comb begin
    // NOTE: every variable gets its hold/idle value first, so no path through
    // the decision tree leaves one unassigned and no latch is inferred.
    tod_d     = tod_q;
    pm_d      = pm_q;
    pending_d = pending_q;
    lost_d    = lost_q;
    sec_d     = 1'b0;
    min_d     = 1'b0;
    hr_d      = 1'b0;
    err_d     = 1'b0;

    // Deferral slot: stopped clock discards it; a user action parks the tick
    // (a second parked tick is lost); otherwise the slot drains while a tick
    // arriving alongside a pending one takes its place.
    if (!i_run) begin
      pending_d = 1'b0;
    end else if (user_event) begin
      if (i_tick_1hz) begin
        if (pending_q) lost_d = 1'b1;
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q & i_tick_1hz;
    end

    if (i_load) begin
      if (load_ok(load_val)) begin
        tod_d     = load_val;
        pm_d      = i_load_pm & !HOUR_24;
        pending_d = tick;
        lost_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (i_inc_hr) begin
      tod_d.hh = inc_hour(tod_q.hh);
      if (pm_flips(tod_q.hh)) pm_d = ~pm_q;
    end else if (i_inc_min) begin
      tod_d.mm = inc_60(tod_q.mm);
      tod_d.ss = 8'h00;
    end else if (i_run && (i_tick_1hz || pending_q)) begin
      sec_d    = 1'b1;
      tod_d.ss = inc_60(tod_q.ss);
      if (tod_q.ss == 8'h59) begin
        min_d    = 1'b1;
        tod_d.mm = inc_60(tod_q.mm);
        if (tod_q.mm == 8'h59) begin
          hr_d     = 1'b1;
          tod_d.hh = inc_hour(tod_q.hh);
          if (pm_flips(tod_q.hh)) pm_d = ~pm_q;
        end
      end
    end
  end

  // State and strobe registers; reset takes effect asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values computed above, independent of statement order.
    if (i_reset) begin
      tod_q     <= '{hh: HR_RESET, mm: 8'h00, ss: 8'h00};
      pm_q      <= 1'b0;
      pending_q <= 1'b0;
      lost_q    <= 1'b0;
      sec_q     <= 1'b0;
      min_q     <= 1'b0;
      hr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tod_q     <= tod_d;
      pm_q      <= pm_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      err_q     <= err_d;
    end
  end

  assign o_time      = tod_q;
  assign o_pm        = pm_q;
  assign o_sec_pulse = sec_q;
  assign o_min_pulse = min_q;
  assign o_hr_pulse  = hr_q;
  assign o_load_err  = err_q;
  assign o_tick_lost = lost_q;

endmodule
